i2c_poll_scheduler: RTL

I2C_POLL_SCHEDULER -- requirements
Module: i2c_poll_scheduler

---
 rtl/i2c_poll_scheduler.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_poll_scheduler.sv
// i2c_poll_scheduler: periodically (run) or on demand (trigger) walks up to
// four sensor slots, programs an Avalon-MM I2C bridge for a register read and
// stores the returned data word per slot.
// Optional feature macro: I2C_SCHED_IRQ_EN enables the round-complete irq.
module i2c_poll_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int DEFAULT_PERIOD = 50_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [2:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        irq
);

  typedef enum logic [3:0] {
    IDLE, SELECT, WR_ADDR, WR_DATA, WR_RW, WR_NBYTES, WR_ENA,
    RD_ACKERR, RD_USEDW, RD_FIFO, STORE, DONE
  } state_t;

  localparam logic [2:0]  LAST_SLOT  = 3'(NUM_SLOTS);
  localparam logic [3:0]  SLOT_MASK  = 4'((1 << NUM_SLOTS) - 1);
  localparam logic [31:0] PERIOD_RST = 32'(DEFAULT_PERIOD);

  state_t      state;
  logic        run;
  logic [31:0] period;
  logic [31:0] period_cnt;
  logic [31:0] period_eff;
  logic        tick;
  logic        pending;
  logic        overrun;
  logic        irq_q;
  logic [31:0] slot_cfg [4];
  logic [31:0] slot_result [4];
  logic [3:0]  err_flags;
  logic [3:0]  err_set;
  logic [3:0]  err_clr;
  logic [31:0] round_cnt;
  logic [2:0]  slot_idx;
  logic [7:0]  cur_reg;
  logic [7:0]  cur_nbytes;
  logic [31:0] fifo_data;
  logic [31:0] cfg_sel;
  logic        busy;
  logic        slot_ok;
  logic        wr_ctrl, wr_status, wr_period, wr_cfg, wr_err;
  logic        trig_wr;
  logic        ovr_set, pend_set, ovr_clr;
  logic        unused_read;

  assign unused_read   = s_read;
  assign s_waitrequest = 1'b0;
  assign busy          = (state != IDLE);
  assign slot_ok       = ({1'b0, s_address[1:0]} < LAST_SLOT);
  assign wr_ctrl       = s_write && (s_address == 4'd0);
  assign wr_status     = s_write && (s_address == 4'd1);
  assign wr_period     = s_write && (s_address == 4'd2);
  assign wr_cfg        = s_write && (s_address[3:2] == 2'b01) && slot_ok;
  assign wr_err        = s_write && (s_address == 4'd12);
  assign trig_wr       = wr_ctrl && s_writedata[1] && !s_writedata[0];
  assign err_clr       = wr_err ? s_writedata[3:0] : 4'b0000;
  assign ovr_clr       = wr_status && s_writedata[3];
  assign period_eff    = (period == 32'd0) ? 32'd1 : period;
  assign tick          = run && (period_cnt >= period_eff - 32'd1);
  assign ovr_set       = tick && busy && pending;
  assign pend_set      = tick && busy && !pending;
  assign cfg_sel       = slot_cfg[slot_idx[1:0]];
  assign irq           = irq_q;

  // Host-writable configuration: run bit, poll period and per-slot setup.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run    <= 1'b0;
      period <= PERIOD_RST;
      for (int i = 0; i < 4; i++) slot_cfg[i] <= '0;
    end else begin
      if (wr_ctrl) run <= s_writedata[0];
      if (wr_period) period <= s_writedata;
      if (wr_cfg)
        slot_cfg[s_address[1:0]] <= {s_writedata[31], 7'd0, s_writedata[23:8], 1'b0, s_writedata[6:0]};
    end
  end

  // Free-running period counter, held at zero while run is off.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) period_cnt <= '0;
    else if (!run || tick) period_cnt <= '0;
    else period_cnt <= period_cnt + 32'd1;
  end

  // Error bit for the current slot on a bridge ack error or an empty FIFO.
  always_comb begin
    err_set = 4'b0000;
    if (!m_waitrequest &&
        (((state == RD_ACKERR) && m_readdata[0]) || ((state == RD_USEDW) && (m_readdata == 32'd0))))
      err_set = 4'b0001 << slot_idx[1:0];
  end

`ifdef I2C_SCHED_IRQ_EN
  // Round-complete interrupt; a new DONE wins over a same-cycle host clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else irq_q <= (state == DONE) | (irq_q & ~(wr_status & s_writedata[4]));
  end
`else
  assign irq_q = 1'b0;
`endif

  // Poll sequencer: walks the slots and drives the bridge master port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot_idx    <= '0;
      cur_reg     <= '0;
      cur_nbytes  <= '0;
      fifo_data   <= '0;
      m_address   <= '0;
      m_write     <= 1'b0;
      m_writedata <= '0;
      m_read      <= 1'b0;
      err_flags   <= '0;
      round_cnt   <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < 4; i++) slot_result[i] <= '0;
    end else begin
      err_flags <= (err_flags & ~err_clr) | err_set;
      overrun   <= ovr_set | (overrun & ~ovr_clr);
      if (pend_set) pending <= 1'b1;
      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (trig_wr || tick) begin
            slot_idx <= '0;
            state    <= SELECT;
          end
        end
        SELECT: begin
          if (slot_idx >= LAST_SLOT) begin
            state <= DONE;
          end else if (cfg_sel[31]) begin
            cur_reg     <= cfg_sel[15:8];
            cur_nbytes  <= cfg_sel[23:16];
            m_write     <= 1'b1;
            m_address   <= 3'd0;
            m_writedata <= {25'd0, cfg_sel[6:0]};
            state       <= WR_ADDR;
          end else begin
            slot_idx <= slot_idx + 3'd1;
          end
        end
        WR_ADDR: if (!m_waitrequest) begin
          m_address   <= 3'd1;
          m_writedata <= {cur_reg, 24'h0};
          state       <= WR_DATA;
        end
        WR_DATA: if (!m_waitrequest) begin
          m_address   <= 3'd2;
          m_writedata <= 32'd1;
          state       <= WR_RW;
        end
        WR_RW: if (!m_waitrequest) begin
          m_address   <= 3'd4;
          m_writedata <= {24'd0, cur_nbytes};
          state       <= WR_NBYTES;
        end
        WR_NBYTES: if (!m_waitrequest) begin
          m_address   <= 3'd3;
          m_writedata <= 32'd1;
          state       <= WR_ENA;
        end
        WR_ENA: if (!m_waitrequest) begin
          m_write     <= 1'b0;
          m_writedata <= '0;
          m_read      <= 1'b1;
          m_address   <= 3'd5;
          state       <= RD_ACKERR;
        end
        RD_ACKERR: if (!m_waitrequest) begin
          if (m_readdata[0]) begin
            m_read    <= 1'b0;
            m_address <= 3'd0;
            slot_idx  <= slot_idx + 3'd1;
            state     <= SELECT;
          end else begin
            m_address <= 3'd6;
            state     <= RD_USEDW;
          end
        end
        RD_USEDW: if (!m_waitrequest) begin
          if (m_readdata == 32'd0) begin
            m_read    <= 1'b0;
            m_address <= 3'd0;
            slot_idx  <= slot_idx + 3'd1;
            state     <= SELECT;
          end else begin
            m_address <= 3'd1;
            state     <= RD_FIFO;
          end
        end
        RD_FIFO: if (!m_waitrequest) begin
          fifo_data <= m_readdata;
          m_read    <= 1'b0;
          m_address <= 3'd0;
          state     <= STORE;
        end
        STORE: begin
          slot_result[slot_idx[1:0]] <= fifo_data;
          slot_idx <= slot_idx + 3'd1;
          state    <= SELECT;
        end
        DONE: begin
          round_cnt <= round_cnt + 32'd1;
          pending   <= 1'b0;
          if (run && (pending || tick)) begin
            slot_idx <= '0;
            state    <= SELECT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host read mux; unmapped or out-of-range slot addresses return a marker.
  always_comb begin
    s_readdata = 32'hDEAD_BEEF;
    case (s_address)
      4'd0: s_readdata = {31'd0, run};
      4'd1: s_readdata = {27'd0, irq_q, overrun, slot_idx[1:0], busy};
      4'd2: s_readdata = period;
      4'd4, 4'd5, 4'd6, 4'd7: if (slot_ok) s_readdata = slot_cfg[s_address[1:0]];
      4'd8, 4'd9, 4'd10, 4'd11: if (slot_ok) s_readdata = slot_result[s_address[1:0]];
      4'd12: s_readdata = {28'd0, err_flags & SLOT_MASK};
      4'd13: s_readdata = round_cnt;
      default: ;
    endcase
  end

endmodule
